// File: rtl/display_pkg.sv
// Shared types and constants for the display arbiter and related blocks.
package display_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned DISP_W  = 4 * DIGIT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Bits needed for a counter that must reach 'cycles' without wrapping.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = 32'd1;
        if (cycles >= 32'd1) begin
            w = $clog2(cycles + 32'd1);
        end
        return w;
    endfunction

endpackage

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_owner, wrapping;
// last_owner itself is considered last.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_owner_i,
    output logic [N_REQ-1:0] pick_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] idx;

    // Scan offsets 1..N_REQ from the last owner, keep the first active request.
    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = IDX_W'((32'(last_owner_i) + off) % N_REQ);
            if (!valid_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner arbitration for the shared 4-digit hex display with a
// minimum dwell time per owner. Optional blank gap between owners when
// DISPLAY_ARB_GAP_EN is defined.
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES   = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [DISP_W*N_REQ-1:0] data_in,
    output logic [N_REQ-1:0]        grant,
    output logic [DISP_W-1:0]       data,
    output logic                    enable
);

    localparam int unsigned IDX_W   = $clog2(N_REQ);
    localparam int unsigned CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYCLES - 32'd1);

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [N_REQ-1:0]   grant_q,  grant_d;
    logic [IDX_W-1:0]   owner_q,  owner_d;
    logic [DISP_W-1:0]  data_q,   data_d;
    logic               enable_q, enable_d;

    logic [N_REQ-1:0]   pick;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [DISP_W-1:0]  owner_data;
    logic               others_req;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req_i        (req),
        .last_owner_i (owner_q),
        .pick_o       (pick),
        .valid_o      (pick_valid)
    );

    // One-hot pick to index.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    // Select the current owner's data word.
    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) owner_data = data_in[i*DISP_W +: DISP_W];
        end
    end

    assign others_req = |(req & ~grant_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        data_d   = data_q;
        enable_d = enable_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d  = pick;
                    owner_d  = pick_idx;
                    cnt_d    = '0;
                    enable_d = 1'b1;
                    state_d  = OWNED;
                end
            end
            OWNED: begin
                data_d = owner_data;
                if (!req[owner_q]) begin
                    // Release wins over a dwell expiry in the same cycle.
                    grant_d  = '0;
                    enable_d = 1'b0;
                    cnt_d    = '0;
`ifdef DISPLAY_ARB_GAP_EN
                    state_d  = GAP;
`else
                    state_d  = IDLE;
`endif
                end else if (cnt_q == DWELL_END) begin
                    if (others_req) begin
`ifdef DISPLAY_ARB_GAP_EN
                        grant_d  = '0;
                        enable_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = GAP;
`else
                        grant_d  = pick;
                        owner_d  = pick_idx;
                        cnt_d    = '0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q >= GAP_END) begin
                    cnt_d = '0;
                    if (pick_valid) begin
                        grant_d  = pick;
                        owner_d  = pick_idx;
                        enable_d = 1'b1;
                        state_d  = OWNED;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d  = '0;
                enable_d = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            owner_q  <= IDX_W'(N_REQ - 32'd1);
            data_q   <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            enable_q <= enable_d;
        end
    end

    assign grant  = grant_q;
    assign data   = data_q;
    assign enable = enable_q;

endmodule
